// File: rtl/alu_bk_pkg.sv
// -----------------------------------------------------------------------------
// alu_bk_pkg
// Shared definitions for the nibble-serial Brent-Kung arithmetic blocks:
//   - op_e     : command encoding (ADD, SUB, CMP, ADDC)
//   - state_e  : sequencer states (IDLE, RUN, DONE)
//   - NIB_W    : width of the slice handled by the shared adder per cycle
//   - helpers  : B-inversion decode and initial carry-in selection
// Also used by the ALU top level and by the bench.
// -----------------------------------------------------------------------------
package alu_bk_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_ADDC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // SUB and CMP both compute a + ~b + 1; they differ only in result write-back.
    function automatic logic op_inverts_b(input op_e op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Carry fed into nibble 0. ADDC consumes the flag left by the previous
    // completed op so that wider words can be built from several commands.
    function automatic logic op_init_cin(input op_e op, input logic carry_flag);
        logic cin;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_SUB:  cin = 1'b1;
            OP_CMP:  cin = 1'b1;
            OP_ADDC: cin = carry_flag;
            default: cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage : alu_bk_pkg

// File: rtl/Sumador_BK.sv
// -----------------------------------------------------------------------------
// Sumador_BK
// 4-bit Brent-Kung parallel-prefix adder with carry-in.
// Ports:
//   a, b : input  [3:0]  operands
//   cin  : input         carry-in
//   sum  : output [3:0]  a + b + cin (low 4 bits)
//   c    : output        carry-out
// Purely combinational.
// -----------------------------------------------------------------------------
module Sumador_BK (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c
);

    logic [3:0] g;
    logic [3:0] p;
    logic       g0c;   // bit-0 generate with cin folded in
    logic       g10;   // group generate, bits 1..0
    logic       g32;   // group generate, bits 3..2
    logic       p32;   // group propagate, bits 3..2
    logic       g20;   // group generate, bits 2..0 (inverse-tree node)
    logic       g30;   // group generate, bits 3..0
    logic [3:0] carry_in_bit;

    assign g = a & b;
    assign p = a ^ b;

    // Folding cin into bit 0 turns the prefix tree into a plain 4-bit tree.
    assign g0c = g[0] | (p[0] & cin);

    // Up-sweep.
    assign g10 = g[1] | (p[1] & g0c);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);

    // Down-sweep fills in the odd prefix that the up-sweep skipped.
    assign g20 = g[2] | (p[2] & g10);

    assign carry_in_bit = {g20, g10, g0c, cin};
    assign sum          = p ^ carry_in_bit;
    assign c            = g30;

endmodule : Sumador_BK

// File: rtl/secuenciador_bk.sv
// -----------------------------------------------------------------------------
// secuenciador_bk
// Multi-cycle arithmetic sequencer: wide ADD / SUB / CMP / ADDC computed one
// nibble per cycle, LSB first, through a single shared 4-bit Brent-Kung adder.
//
// Parameters:
//   NIBBLES   : operand width W = 4*NIBBLES bits (1..16)
// Ports:
//   clk       : in   clock, rising edge
//   rst_n     : in   asynchronous active-low reset
//   in_valid  : in   command present
//   in_ready  : out  high in IDLE
//   op        : in   [1:0] 00 ADD, 01 SUB, 10 CMP, 11 ADDC
//   a, b      : in   [W-1:0] operands
//   out_valid : out  high in DONE
//   out_ready : in   consumer takes result
//   result    : out  [W-1:0] sum/difference, zero for CMP
//   carry     : out  carry-out (ADD/ADDC) or borrow (SUB/CMP)
//   zero      : out  full W-bit add/sub value was zero
// Latency: out_valid rises NIBBLES edges after the accept edge. All outputs
// are registers or state decodes; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module secuenciador_bk
    import alu_bk_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     carry,
    output logic                     zero
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             zero_acc_q, zero_acc_d;
    logic             chain_q, chain_d;     // carry-out of the previous nibble

    // Command registers (datapath only, loaded on accept).
    op_e              op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    // ------------------------------------------------------------------
    // Adder datapath
    // ------------------------------------------------------------------
    logic [NIB_W-1:0] add_a;
    logic [NIB_W-1:0] add_b;
    logic [NIB_W-1:0] add_sum;
    logic             add_cin;
    logic             add_cout;
    logic             sub_mode;
    logic             nib_zero;
    logic             accept;
    logic             last_nib;

    assign accept   = in_valid && (state_q == IDLE);
    assign sub_mode = op_inverts_b(op_q);
    assign last_nib = (idx_q == IDX_LAST);

    assign add_a    = a_q[NIB_W*int'(idx_q) +: NIB_W];
    assign add_b    = sub_mode ? ~b_q[NIB_W*int'(idx_q) +: NIB_W]
                               :  b_q[NIB_W*int'(idx_q) +: NIB_W];
    assign add_cin  = (idx_q == '0) ? op_init_cin(op_q, carry_q) : chain_q;
    assign nib_zero = (add_sum == '0);

    Sumador_BK u_sumador (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .c   (add_cout)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath update
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        zero_acc_d = zero_acc_q;
        chain_d    = chain_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    zero_acc_d = 1'b1;
                    // Cleared here so CMP leaves an all-zero result.
                    result_d   = '0;
                end
            end

            RUN: begin
                if (op_q != OP_CMP) begin
                    result_d[NIB_W*int'(idx_q) +: NIB_W] = add_sum;
                end
                zero_acc_d = zero_acc_q & nib_zero;
                chain_d    = add_cout;
                if (last_nib) begin
                    // SUB/CMP report borrow, the complement of carry-out.
                    carry_d = sub_mode ? ~add_cout : add_cout;
                    zero_d  = zero_acc_q & nib_zero;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and flag registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            zero_acc_q <= 1'b1;
            chain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            zero_acc_q <= zero_acc_d;
            chain_q    <= chain_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always written on
    // accept before the RUN state reads them, so a reset would only add
    // fan-out on rst_n without changing behaviour.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_e'(op);
            a_q  <= a;
            b_q  <= b;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule : secuenciador_bk

// File: tb/tb_secuenciador_bk.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_bk
// Directed, table-driven bench for secuenciador_bk at NIBBLES = 4, plus
// hand-written sequences for backpressure and reset during RUN.
// -----------------------------------------------------------------------------
module tb_secuenciador_bk;
    import alu_bk_pkg::*;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int checks;
    int errors;

    secuenciador_bk #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_e          vop;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_result;
        logic         exp_carry;
        logic         exp_zero;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return just after the accept edge.
    task automatic start_op(input op_e o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input string name);
        for (int k = 0; k < TIMEOUT; k++) begin
            if (in_ready) break;
            tick();
        end
        check({name, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        a        = xa;
        b        = xb;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        start_op(v.vop, v.va, v.vb, name);
        check({name, "_busy"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        check({name, "_latency"}, 32'(lat), 32'(NIBBLES));
        check({name, "_result"}, 32'(result), 32'(v.exp_result));
        check({name, "_carry"}, 32'(carry), 32'(v.exp_carry));
        check({name, "_zero"}, 32'(zero), 32'(v.exp_zero));
        // out_ready is high: DONE must last exactly one cycle.
        tick();
        check({name, "_done_1cyc"}, 32'(out_valid), 32'd0);
        check({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] held_result;
        vec_t         v;

        checks = 0;
        errors = 0;

        // Sequence-dependent: ADDC rows consume the flag of the row above.
        vecs[0] = '{OP_ADD,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{OP_SUB,  16'h1234, 16'h1235, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{OP_SUB,  16'h1235, 16'h1234, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{OP_CMP,  16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{OP_CMP,  16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{OP_ADDC, 16'h1234, 16'h1111, 16'h2346, 1'b0, 1'b0};
        vecs[8] = '{OP_SUB,  16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        a         = '0;
        b         = '0;

        #2;
        check("rst_result", 32'(result), 32'h0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        #10 rst_n = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        start_op(OP_ADD, 16'h1111, 16'h2222, "bp");
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'(NIBBLES));
        check("bp_result", 32'(result), 32'h3333);
        held_result = result;
        // A competing command is offered while the result is held.
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 16'h0001;
        b        = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_result", k), 32'(result), 32'(held_result));
            check($sformatf("bp_hold%0d_flags", k), 32'({carry, zero}), 32'b00);
        end
        out_ready = 1'b1;
        tick();
        check("bp_back_idle", 32'(in_ready), 32'd1);
        check("bp_back_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("bp2_latency", 32'(lat), 32'(NIBBLES));
        check("bp2_result", 32'(result), 32'h0002);
        check("bp2_flags", 32'({carry, zero}), 32'b00);
        tick();

        // ---------------- reset during RUN ----------------
        v = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        run_vec(v, "pre_rst");
        start_op(OP_ADD, 16'h1234, 16'h0001, "mid");
        tick();
        tick();     // idx is now 2
        check("mid_running", 32'({in_ready, out_valid}), 32'b00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 32'h0);
        check("mid_rst_carry", 32'(carry), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_no_output", 32'(out_valid), 32'd0);
        // ADDC right after reset must see a zero carry flag.
        v = '{OP_ADDC, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
        run_vec(v, "post_rst_addc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_secuenciador_bk
